// File: rtl/fa4_rom_responder.sv
// rtl/fa4_rom_responder.sv - FA4 instruction-bus program ROM responder
// Samples a 12-bit fetch address as three nibbles after sync and returns one 8-bit word as two nibbles.
module fa4_rom_responder #(
  parameter logic [3:0] CHIP_ID = 4'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sync,
  input  logic [3:0]  bus_in,
  output logic [3:0]  bus_out,
  output logic        bus_oe,
  input  logic        prog_we,
  input  logic [7:0]  prog_addr,
  input  logic [7:0]  prog_data,
  output logic [11:0] rom_addr,
  output logic        fetch_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_A1, S_A2, S_A3, S_M1, S_M2, S_X1, S_X2, S_X3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  lo_q, lo_d, mid_q, mid_d;
  logic [7:0]  word_q, word_d;
  logic        sel_q, sel_d;
  logic [3:0]  bus_out_q, bus_out_d;
  logic        oe_q, oe_d;
  logic        fd_q, fd_d;
  logic [11:0] rom_addr_q, rom_addr_d;

  // Program array is deliberately left out of reset; contents survive it.
  logic [7:0]  mem [256];

  always_ff @(posedge clock) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      lo_q       <= 4'h0;
      mid_q      <= 4'h0;
      word_q     <= 8'h00;
      sel_q      <= 1'b0;
      bus_out_q  <= 4'h0;
      oe_q       <= 1'b0;
      fd_q       <= 1'b0;
      rom_addr_q <= 12'h000;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      mid_q      <= mid_d;
      word_q     <= word_d;
      sel_q      <= sel_d;
      bus_out_q  <= bus_out_d;
      oe_q       <= oe_d;
      fd_q       <= fd_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    mid_d      = mid_q;
    word_d     = word_q;
    sel_d      = sel_q;
    bus_out_d  = bus_out_q;
    oe_d       = oe_q;
    fd_d       = fd_q;
    rom_addr_d = rom_addr_q;
    // sync overrides whatever the current state would have done, aborting any fetch in flight
    if (sync) begin
      state_d   = S_A1;
      bus_out_d = 4'h0;
      oe_d      = 1'b0;
      fd_d      = 1'b0;
    end else begin
      case (state_q)
        S_A1: begin
          lo_d    = bus_in;
          state_d = S_A2;
        end
        S_A2: begin
          mid_d   = bus_in;
          word_d  = mem[{bus_in, lo_q}];
          state_d = S_A3;
        end
        S_A3: begin
          rom_addr_d = {bus_in, mid_q, lo_q};
          sel_d      = (bus_in == CHIP_ID);
          bus_out_d  = sel_d ? word_q[7:4] : 4'h0;
          oe_d       = sel_d;
          state_d    = S_M1;
        end
        S_M1: begin
          bus_out_d = sel_q ? word_q[3:0] : 4'h0;
          fd_d      = sel_q;
          state_d   = S_M2;
        end
        S_M2: begin
          bus_out_d = 4'h0;
          oe_d      = 1'b0;
          fd_d      = 1'b0;
          state_d   = S_X1;
        end
        S_X1:    state_d = S_X2;
        S_X2:    state_d = S_X3;
        S_X3:    state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus_out    = bus_out_q;
  assign bus_oe     = oe_q;
  assign fetch_done = fd_q;
  assign rom_addr   = rom_addr_q;

endmodule

// File: tb/tb_fa4_rom_responder.sv
// tb/tb_fa4_rom_responder.sv - self-checking bench for fa4_rom_responder
// Vector table, hand-built corner sequences, and random fetches against an array model.
module tb_fa4_rom_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sync = 1'b0;
  logic [3:0]  bus_in = 4'h0;
  logic [3:0]  bus_out;
  logic        bus_oe;
  logic        prog_we = 1'b0;
  logic [7:0]  prog_addr = 8'h00;
  logic [7:0]  prog_data = 8'h00;
  logic [11:0] rom_addr;
  logic        fetch_done;

  fa4_rom_responder #(.CHIP_ID(4'h0)) dut (
    .clock(clock), .reset(reset), .sync(sync), .bus_in(bus_in),
    .bus_out(bus_out), .bus_oe(bus_oe), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .rom_addr(rom_addr), .fetch_done(fetch_done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_m1  = -1;
  logic [7:0] tb_mem [256];

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] a1, a2, a3, hi, lo;
    bit         sel;
  } vec_t;
  vec_t tbl [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic prog(input logic [7:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    step();
    prog_we = 1'b0;
    tb_mem[a] = d;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " oe"}, {31'd0, bus_oe}, 0);
    chk({tag, " out"}, {28'd0, bus_out}, 0);
    chk({tag, " done"}, {31'd0, fetch_done}, 0);
  endtask

  // Full fetch from sync through X3; optionally writes the model array on the A2 edge.
  task automatic fetch(input logic [3:0] a1, a2, a3, hi, lo, input bit sel,
                       input bit wr, input logic [7:0] wa, wd, input string tag);
    sync = 1'b1; step();
    sync = 1'b0; bus_in = a1; step();
    bus_in = a2;
    if (wr) begin prog_we = 1'b1; prog_addr = wa; prog_data = wd; end
    step();
    prog_we = 1'b0;
    if (wr) tb_mem[wa] = wd;
    bus_in = a3; step();
    chk({tag, " M1 out"}, {28'd0, bus_out}, {28'd0, hi});
    chk({tag, " M1 oe"}, {31'd0, bus_oe}, {31'd0, sel});
    chk({tag, " M1 done"}, {31'd0, fetch_done}, 0);
    chk({tag, " rom_addr"}, {20'd0, rom_addr}, {20'd0, a3, a2, a1});
    last_m1 = cyc;
    bus_in = 4'($urandom); step();
    chk({tag, " M2 out"}, {28'd0, bus_out}, {28'd0, lo});
    chk({tag, " M2 oe"}, {31'd0, bus_oe}, {31'd0, sel});
    chk({tag, " M2 done"}, {31'd0, fetch_done}, {31'd0, sel});
    step();
    chk_quiet({tag, " X1"});
    step(); step();
  endtask

  initial begin
    logic [11:0] held;
    int prev_m1;
    tbl[0] = '{a1: 4'hA, a2: 4'h3, a3: 4'h0, hi: 4'hC, lo: 4'h5, sel: 1'b1};
    tbl[1] = '{a1: 4'hA, a2: 4'h3, a3: 4'h2, hi: 4'h0, lo: 4'h0, sel: 1'b0};
    tbl[2] = '{a1: 4'hB, a2: 4'h3, a3: 4'h0, hi: 4'h9, lo: 4'h1, sel: 1'b1};

    #12;
    chk_quiet("reset");
    chk("reset rom_addr", {20'd0, rom_addr}, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus_in = 4'($urandom); step();
      chk_quiet("idle");
      chk("idle rom_addr", {20'd0, rom_addr}, 0);
    end

    for (int i = 0; i < 256; i++) prog(8'(i), 8'($urandom));
    prog(8'h3A, 8'hC5);
    prog(8'h3B, 8'h91);

    step();
    for (int i = 0; i < 3; i++) begin
      prev_m1 = last_m1;
      fetch(tbl[i].a1, tbl[i].a2, tbl[i].a3, tbl[i].hi, tbl[i].lo, tbl[i].sel,
            1'b0, 8'h00, 8'h00, $sformatf("vec%0d", i));
      if (i > 0) chk("back-to-back spacing", last_m1 - prev_m1, 8);
    end

    fetch(4'hB, 4'h3, 4'h0, 4'h9, 4'h1, 1'b1, 1'b1, 8'h3B, 8'h77, "collide");
    fetch(4'hB, 4'h3, 4'h0, 4'h7, 4'h7, 1'b1, 1'b0, 8'h00, 8'h00, "after collide");

    // resync during M1, then a fresh address from A1 without another sync
    sync = 1'b1; step();
    sync = 1'b0; bus_in = 4'hB; step();
    bus_in = 4'h3; step();
    bus_in = 4'h0; step();
    chk("resync M1 oe", {31'd0, bus_oe}, 1);
    sync = 1'b1; step();
    sync = 1'b0;
    chk_quiet("resync");
    bus_in = 4'hA; step();
    bus_in = 4'h3; step();
    bus_in = 4'h0; step();
    chk("resync M1 out", {28'd0, bus_out}, 4'hC);
    chk("resync M1 oe2", {31'd0, bus_oe}, 1);
    step();
    chk("resync M2 out", {28'd0, bus_out}, 4'h5);
    chk("resync M2 done", {31'd0, fetch_done}, 1);
    step(); step(); step();

    // sync on the A3 edge aborts the fetch and leaves rom_addr alone
    held = rom_addr;
    sync = 1'b1; step();
    sync = 1'b0; bus_in = 4'h1; step();
    bus_in = 4'h2; step();
    sync = 1'b1; bus_in = 4'h0; step();
    sync = 1'b0;
    chk("abort rom_addr", {20'd0, rom_addr}, {20'd0, held});
    chk_quiet("abort");
    step(); step(); step(); step(); step(); step(); step(); step();

    // asynchronous reset in M2
    sync = 1'b1; step();
    sync = 1'b0; bus_in = 4'hA; step();
    bus_in = 4'h3; step();
    bus_in = 4'h0; step();
    step();
    chk("pre-reset M2 done", {31'd0, fetch_done}, 1);
    #2 reset = 1'b1;
    #1;
    chk_quiet("async reset");
    chk("async reset rom_addr", {20'd0, rom_addr}, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus_in = 4'($urandom); step();
      chk_quiet("post-reset");
    end
    fetch(4'hA, 4'h3, 4'h0, 4'hC, 4'h5, 1'b1, 1'b0, 8'h00, 8'h00, "preserved");

    // random fetches against the array model
    for (int i = 0; i < 60; i++) begin
      logic [3:0] a1, a2, a3;
      logic [7:0] w, wd;
      bit sel, wr;
      a1 = 4'($urandom); a2 = 4'($urandom);
      a3 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      wr = ($urandom_range(0, 3) == 0);
      wd = 8'($urandom);
      w = tb_mem[{a2, a1}];
      sel = (a3 == 4'h0);
      if ($urandom_range(0, 2) == 0) begin
        prog(8'($urandom), 8'($urandom));
        w = tb_mem[{a2, a1}];
      end
      fetch(a1, a2, a3, sel ? w[7:4] : 4'h0, sel ? w[3:0] : 4'h0, sel,
            wr, {a2, a1}, wd, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fa4_rom_responder.md
# fa4_rom_responder

Program-memory responder on the far end of the FA4 CPU's 4-bit multiplexed instruction bus. It receives the 12-bit fetch address as three nibbles after a `sync` strobe and returns the addressed 8-bit instruction word as two nibbles on the same bus. The chip-select nibble is compared with `CHIP_ID`, so several instances can share one bus. A side-band programming port loads the 256×8 array before the CPU runs.

## Interface
- `CHIP_ID`, 4'h0: address nibble A3 value this instance answers to.
- `clock`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sync`  in  1  CPU strobe; high for one cycle immediately before the A1 cycle.
- `bus_in`  in  4  nibble driven by CPU during A1/A2/A3.
- `bus_out`  out  4  nibble returned during M1/M2; 0 otherwise.
- `bus_oe`  out  1  high while `bus_out` is valid for this chip.
- `prog_we`  in  1  write strobe for programming port.
- `prog_addr`  in  8  programming row address.
- `prog_data`  in  8  programming data, {opcode nibble, operand nibble}.
- `rom_addr`  out  12  last fetched address {A3,A2,A1}.
- `fetch_done`  out  1  one-cycle pulse during M2 of a selected fetch.

## Operation
- States: IDLE, A1, A2, A3, M1, M2, X1, X2, X3. The state is registered.
- `sync` high at any edge moves the state to A1 on that edge, from any state. This is the resync rule. Otherwise the states advance as A1→A2→A3→M1→M2→X1→X2→X3→IDLE, and IDLE holds.
- End of A1 edge: `lo <= bus_in`.
- End of A2 edge: `mid <= bus_in`; `word <= mem[{bus_in, lo}]`. This is a synchronous read-first read.
- End of A3 edge: `rom_addr <= {bus_in, mid, lo}`; `sel <= (bus_in == CHIP_ID)`; `bus_out <= sel ? word[7:4] : 0`; `bus_oe <= sel`.
- End of M1 edge: `bus_out <= sel ? word[3:0] : 0`; `bus_oe` holds; `fetch_done <= sel`.
- End of M2 edge: `bus_out <= 0`; `bus_oe <= 0`; `fetch_done <= 0`.
- `rom_addr` updates on every A3, selected or not.
- Resync (`sync` high) in any state also forces `bus_oe <= 0`, `bus_out <= 0` and `fetch_done <= 0` on the same edge.
- Programming: `prog_we` high at an edge writes `mem[prog_addr] <= prog_data`. Writes are accepted in every state.
- Read/write collision: a write and an A2 read to the same row on the same edge return the old data; the new data is seen on the next fetch.
- The memory array is not cleared by reset. Contents are undefined until programmed.

## Timing
- Reset values: state IDLE; `bus_out` 0; `bus_oe` 0; `fetch_done` 0; `rom_addr` 0; `sel` 0; `lo`, `mid`, `word` 0.
- Reset takes effect asynchronously. Outputs go to reset values without waiting for a clock edge, including mid-fetch.
- Latency: opcode nibble is valid on the cycle after the A3 sample (M1). The operand nibble follows one cycle later (M2).
- `bus_oe` is high for exactly 2 cycles per selected fetch and never outside M1/M2.
- Instruction cycle is 8 clocks, A1–X3. `sync` asserted during X3 gives back-to-back fetches with no IDLE cycle.
- `bus_in` is ignored in all states except A1/A2/A3.
- A `sync` during the A3 edge aborts that fetch: `rom_addr` is not updated.

## Test plan
- Reset/idle: assert `reset` → `bus_oe`=0, `bus_out`=0, `fetch_done`=0, `rom_addr`=0. Toggle `bus_in` for 20 cycles without `sync` → outputs unchanged.
- Basic fetch: program `mem[8'h3A]`=8'hC5, CHIP_ID=0. Pulse `sync`, drive A,3,0 → M1: `bus_out`=C, `bus_oe`=1. M2: `bus_out`=5, `fetch_done`=1. X1: `bus_oe`=0. `rom_addr`=12'h03A.
- Chip mismatch: same fetch with A3 nibble=2 → `bus_oe` stays 0 and `bus_out` stays 0 in M1/M2, `fetch_done`=0, `rom_addr`=12'h23A.
- Back-to-back and collision: `sync` in X3, second address 8'h3B (mem=8'h91) → M1 of the second fetch falls exactly 8 cycles after the first, returning 9 then 1. Then `prog_we` writes 8'h3B=8'h77 on the A2 edge of a third fetch → that fetch returns 9,1 and the next returns 7,7.
- Resync: `sync` pulsed during M1 → `bus_oe`=0 on the next edge, state A1. A new address completes normally.
- Reset mid-operation: assert `reset` during M2 → `bus_oe`, `bus_out` and `fetch_done` drop to 0 before the next edge. After release, no drive until the next `sync`, and programmed contents are preserved.
